mem_port_arbiter: RTL and testbench

Shares one single-port memory bus between the instruction-fetch stage (IF) and the data-memory stage (DM) of the 5-stage RV32I pipeline. It allows one outstanding bus transaction at a time, with data priority and a starvation guard for fetch. Fetch responses are discarded on a flush from the pipeline control (branch taken or jump). Per-requester grants are the stall source for the fetch and memory stages.

---
 rtl/proc_pkg.sv | 17 +
 rtl/mem_arb_prio.sv | 38 +++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the IF/DM memory-port arbiter.
package proc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_GNT,
        ARB_WAIT_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection (data priority with fetch starvation guard) and the starvation-count update.
// Purely combinational; grants only inside the arbitration window.
module mem_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       arb_win_i,
    input  logic       if_req_i,
    input  logic       dm_req_i,
    input  logic       flush_i,
    input  logic [3:0] cnt_q_i,
    output logic       if_win_o,
    output logic       dm_win_o,
    output logic [3:0] cnt_d_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic if_ok;
    logic force_if;

    always_comb begin
        // A redirect makes the pending fetch address stale, so IF cannot win then.
        if_ok    = if_req_i & ~flush_i;
        force_if = if_ok & (cnt_q_i == LIMIT);
        dm_win_o = arb_win_i & dm_req_i & ~force_if;
        if_win_o = arb_win_i & if_ok & ~dm_win_o;

        cnt_d_o = cnt_q_i;
        if (dm_win_o && if_req_i) begin
            if (cnt_q_i != LIMIT) begin
                cnt_d_o = cnt_q_i + 4'd1;
            end
        end else if (if_win_o || (arb_win_i && !if_req_i)) begin
            cnt_d_o = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between fetch and data stages, one transaction in flight.
// Grant is combinational; bus_req_o follows 1 cycle later and holds until bus_gnt_i.
module mem_port_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_be_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [31:0]       dm_rdata_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_be_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              proto_err_o
);

    arb_state_t        state_q;
    arb_owner_t        owner_q;
    logic              kill_q;
    logic              we_q;
    logic              proto_q;
    logic [3:0]        be_q;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rsp;
    logic              arb_win;
    logic              if_win;
    logic              dm_win;

    assign rsp     = (state_q == ARB_WAIT_RESP) && bus_rvalid_i;
    assign arb_win = (state_q == ARB_IDLE) || rsp;

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .arb_win_i(arb_win),
        .if_req_i (if_req_i),
        .dm_req_i (dm_req_i),
        .flush_i  (flush_i),
        .cnt_q_i  (cnt_q),
        .if_win_o (if_win),
        .dm_win_o (dm_win),
        .cnt_d_o  (cnt_d)
    );

    assign if_gnt_o    = if_win;
    assign dm_gnt_o    = dm_win;
    assign if_rvalid_o = rsp && (owner_q == OWN_IF) && !kill_q && !flush_i;
    assign dm_rvalid_o = rsp && (owner_q == OWN_DM);
    assign if_rdata_o  = if_rvalid_o ? bus_rdata_i : '0;
    assign dm_rdata_o  = (dm_rvalid_o && !we_q) ? bus_rdata_i : '0;

    assign bus_req_o   = (state_q == ARB_WAIT_GNT);
    assign bus_we_o    = bus_req_o ? we_q : 1'b0;
    assign bus_be_o    = bus_req_o ? be_q : 4'h0;
    assign bus_addr_o  = bus_req_o ? addr_q : '0;
    assign bus_wdata_o = bus_req_o ? wdata_q : '0;
    assign proto_err_o = proto_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IF;
            kill_q  <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            proto_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (bus_rvalid_i && state_q != ARB_WAIT_RESP) begin
                proto_q <= 1'b1;
            end
            if (flush_i && owner_q == OWN_IF && state_q != ARB_IDLE) begin
                kill_q <= 1'b1;
            end
            if (rsp) begin
                kill_q  <= 1'b0;
                state_q <= ARB_IDLE;
            end
            if (state_q == ARB_WAIT_GNT && bus_gnt_i) begin
                state_q <= ARB_WAIT_RESP;
            end
            // A grant in the response cycle issues back-to-back without visiting IDLE.
            if (dm_win || if_win) begin
                state_q <= ARB_WAIT_GNT;
                owner_q <= dm_win ? OWN_DM : OWN_IF;
                addr_q  <= dm_win ? dm_addr_i : if_addr_i;
                we_q    <= dm_win && dm_we_i;
                be_q    <= (dm_win && dm_we_i) ? dm_be_i : BE_ALL;
                wdata_q <= (dm_win && dm_we_i) ? dm_wdata_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int LIM = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          flush_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [31:0]   if_rdata_o;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [3:0]    dm_be_i;
    logic [AW-1:0] dm_addr_i;
    logic [31:0]   dm_wdata_i;
    logic          dm_gnt_o;
    logic          dm_rvalid_o;
    logic [31:0]   dm_rdata_o;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [3:0]    bus_be_o;
    logic [AW-1:0] bus_addr_o;
    logic [31:0]   bus_wdata_o;
    logic          bus_gnt_i;
    logic          bus_rvalid_i;
    logic [31:0]   bus_rdata_i;
    logic          proto_err_o;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_be_i     (dm_be_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_gnt_o    (dm_gnt_o),
        .dm_rvalid_o (dm_rvalid_o),
        .dm_rdata_o  (dm_rdata_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_be_o    (bus_be_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_gnt_i   (bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i (bus_rdata_i),
        .proto_err_o (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    // Transaction-level reference: at most one bus transaction outstanding.
    typedef struct {
        bit          dm;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          killed;
        int          gcyc;
        bit          acc;
        int          acyc;
    } txn_t;

    txn_t        cur;
    bit          cur_v;
    int          starve;
    int          now;
    bit          acc;
    bit          rsp, free, exp_breq, exp_ifv, exp_dmv, exp_if_g, exp_dm_g;
    logic [31:0] exp_ifd, exp_dmd;
    bit          seq[6];
    bit          exp_seq[6];
    int          ng;

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        mid();
        chk("rst_bus_req", 32'(bus_req_o), 0);
        chk("rst_gnts", 32'({if_gnt_o, dm_gnt_o}), 0);
        chk("rst_rvalids", 32'({if_rvalid_o, dm_rvalid_o}), 0);
        chk("rst_bus_fields", bus_addr_o | bus_wdata_o | 32'(bus_be_o) | 32'(bus_we_o), 0);
        chk("rst_proto", 32'(proto_err_o), 0);
        cyc(); rst_n_i = 1'b1;

        // Single fetch: grant cycle 0, bus_req cycle 1, rvalid cycle 3
        cyc(); if_req_i = 1'b1; if_addr_i = 32'h100;
        mid(); chk("if_gnt_c0", 32'(if_gnt_o), 1); chk("if_busreq_c0", 32'(bus_req_o), 0);
        cyc(); if_req_i = 1'b0;
        mid(); chk("if_busreq_c1", 32'(bus_req_o), 1); chk("if_busaddr", bus_addr_o, 32'h100);
        chk("if_busbe", 32'(bus_be_o), 32'hF); chk("if_buswe", 32'(bus_we_o), 0);
        cyc(); bus_gnt_i = 1'b1;
        mid(); chk("if_busreq_c2", 32'(bus_req_o), 1);
        cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
        mid(); chk("if_rvalid_c3", 32'(if_rvalid_o), 1); chk("if_rdata_c3", if_rdata_o, 32'hDEADBEEF);
        chk("if_dmrvalid_c3", 32'(dm_rvalid_o), 0);
        cyc(); bus_rvalid_i = 1'b0;
        mid(); chk("if_idle_after", 32'({bus_req_o, if_rvalid_o}), 0);

        // Simultaneous requests: store wins, fetch issues back-to-back
        cyc(); if_req_i = 1'b1; if_addr_i = 32'h200;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'h3; dm_addr_i = 32'h2000; dm_wdata_i = 32'h1234;
        mid(); chk("both_dm_gnt", 32'(dm_gnt_o), 1); chk("both_if_nogrant", 32'(if_gnt_o), 0);
        cyc(); dm_req_i = 1'b0; bus_gnt_i = 1'b1;
        mid(); chk("st_busreq", 32'(bus_req_o), 1); chk("st_we", 32'(bus_we_o), 1);
        chk("st_be", 32'(bus_be_o), 32'h3); chk("st_addr", bus_addr_o, 32'h2000);
        chk("st_wdata", bus_wdata_o, 32'h1234);
        cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
        mid(); chk("st_ack", 32'(dm_rvalid_o), 1); chk("st_rdata_zero", dm_rdata_o, 0);
        chk("b2b_if_gnt", 32'(if_gnt_o), 1); chk("st_no_if_rvalid", 32'(if_rvalid_o), 0);
        cyc(); bus_rvalid_i = 1'b0; if_req_i = 1'b0; bus_gnt_i = 1'b1;
        mid(); chk("b2b_addr", bus_addr_o, 32'h200); chk("b2b_we", 32'(bus_we_o), 0);
        chk("b2b_be", 32'(bus_be_o), 32'hF);
        cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11112222;
        mid(); chk("b2b_rdata", if_rdata_o, 32'h11112222); chk("b2b_rvalid", 32'(if_rvalid_o), 1);
        cyc(); bus_rvalid_i = 1'b0;

        // Starvation guard: both held high, expect D,D,D,D,I,D
        if_req_i = 1'b1; if_addr_i = 32'h400;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h3000;
        acc = 1'b0; ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            if (c != 0) cyc();
            bus_rvalid_i = acc; bus_rdata_i = $urandom;
            acc = bus_req_o; bus_gnt_i = bus_req_o;
            mid();
            if (dm_gnt_o) begin seq[ng] = 1'b1; ng++; end
            else if (if_gnt_o) begin seq[ng] = 1'b0; ng++; end
        end
        chk("starve_grants", 32'(ng), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("starve_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        if_req_i = 1'b0; dm_req_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            bus_rvalid_i = acc; acc = bus_req_o; bus_gnt_i = bus_req_o;
        end
        cyc(); bus_rvalid_i = 1'b0; bus_gnt_i = 1'b0;

        // Flush kills in-flight fetch, regrant next window, flush in rvalid cycle
        if_req_i = 1'b1; if_addr_i = 32'h300;
        mid(); chk("fl_gnt", 32'(if_gnt_o), 1);
        cyc(); if_req_i = 1'b0; bus_gnt_i = 1'b1;
        mid(); chk("fl_busaddr", bus_addr_o, 32'h300);
        cyc(); bus_gnt_i = 1'b0; flush_i = 1'b1;
        mid(); chk("fl_flush_cycle", 32'(if_rvalid_o), 0);
        cyc(); flush_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h33333333;
        if_req_i = 1'b1; if_addr_i = 32'h304;
        mid(); chk("fl_killed", 32'(if_rvalid_o), 0); chk("fl_regrant", 32'(if_gnt_o), 1);
        cyc(); bus_rvalid_i = 1'b0; if_req_i = 1'b0; bus_gnt_i = 1'b1;
        mid(); chk("fl_new_addr", bus_addr_o, 32'h304); chk("fl_new_req", 32'(bus_req_o), 1);
        cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h44444444; flush_i = 1'b1;
        mid(); chk("fl_same_cycle", 32'(if_rvalid_o), 0); chk("fl_same_rdata", if_rdata_o, 0);
        cyc(); bus_rvalid_i = 1'b0; flush_i = 1'b0;
        mid(); chk("fl_idle", 32'(bus_req_o), 0); chk("fl_no_proto", 32'(proto_err_o), 0);

        // Stray response in IDLE
        cyc(); bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55555555;
        mid(); chk("pe_no_rvalid", 32'({if_rvalid_o, dm_rvalid_o}), 0);
        cyc(); bus_rvalid_i = 1'b0;
        mid(); chk("pe_set", 32'(proto_err_o), 1);
        cyc(); cyc();
        mid(); chk("pe_sticky", 32'(proto_err_o), 1);
        rst_n_i = 1'b0; #1;
        chk("pe_reset_clears", 32'(proto_err_o), 0);
        cyc(); rst_n_i = 1'b1;

        // Reset mid-transaction, late response, then clean DM read
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
        mid(); chk("rs_gnt", 32'(dm_gnt_o), 1);
        cyc(); dm_req_i = 1'b0;
        mid(); chk("rs_busreq", 32'(bus_req_o), 1);
        rst_n_i = 1'b0; #1;
        chk("rs_busreq_drop", 32'(bus_req_o), 0);
        cyc(); rst_n_i = 1'b1; bus_rvalid_i = 1'b1;
        mid(); chk("rs_late_no_rvalid", 32'(dm_rvalid_o), 0);
        cyc(); bus_rvalid_i = 1'b0; dm_req_i = 1'b1;
        mid(); chk("rs_late_proto", 32'(proto_err_o), 1); chk("rs_regrant", 32'(dm_gnt_o), 1);
        cyc(); dm_req_i = 1'b0; bus_gnt_i = 1'b1;
        mid(); chk("rs_addr", bus_addr_o, 32'h40); chk("rs_be", 32'(bus_be_o), 32'hF);
        cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hA5A5A5A5;
        mid(); chk("rs_rvalid", 32'(dm_rvalid_o), 1); chk("rs_rdata", dm_rdata_o, 32'hA5A5A5A5);
        cyc(); bus_rvalid_i = 1'b0; rst_n_i = 1'b0;
        cyc(); rst_n_i = 1'b1;

        // Randomized traffic against the transaction-level reference
        cur_v = 1'b0; starve = 0; now = 0; exp_if_g = 1'b0; exp_dm_g = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            cyc(); now++;
            if (exp_if_g || !if_req_i) begin
                if_req_i = ($urandom_range(0, 2) != 0);
                if_addr_i = $urandom & 32'h0000_FFFC;
            end
            if (exp_dm_g || !dm_req_i) begin
                dm_req_i = ($urandom_range(0, 2) == 0);
                dm_we_i = 1'($urandom); dm_be_i = 4'($urandom);
                dm_addr_i = $urandom & 32'h0000_FFFC; dm_wdata_i = $urandom;
            end
            flush_i = ($urandom_range(0, 5) == 0);
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
            if (cur_v && !cur.acc && cur.gcyc < now) bus_gnt_i = 1'($urandom);
            if (cur_v && cur.acc && cur.acyc < now) bus_rvalid_i = 1'($urandom);
            mid();
            rsp = bus_rvalid_i;
            free = !cur_v || rsp;
            exp_breq = cur_v && !cur.acc && cur.gcyc < now;
            exp_ifv = rsp && !cur.dm && !cur.killed && !flush_i;
            exp_dmv = rsp && cur.dm;
            exp_ifd = exp_ifv ? bus_rdata_i : 32'h0;
            exp_dmd = (exp_dmv && !cur.we) ? bus_rdata_i : 32'h0;
            exp_if_g = 1'b0; exp_dm_g = 1'b0;
            if (free) begin
                if (if_req_i && !flush_i && starve >= LIM) exp_if_g = 1'b1;
                else if (dm_req_i) exp_dm_g = 1'b1;
                else if (if_req_i && !flush_i) exp_if_g = 1'b1;
            end
            chk("rnd_if_gnt", 32'(if_gnt_o), 32'(exp_if_g));
            chk("rnd_dm_gnt", 32'(dm_gnt_o), 32'(exp_dm_g));
            chk("rnd_if_rvalid", 32'(if_rvalid_o), 32'(exp_ifv));
            chk("rnd_dm_rvalid", 32'(dm_rvalid_o), 32'(exp_dmv));
            chk("rnd_if_rdata", if_rdata_o, exp_ifd);
            chk("rnd_dm_rdata", dm_rdata_o, exp_dmd);
            chk("rnd_bus_req", 32'(bus_req_o), 32'(exp_breq));
            if (exp_breq) begin
                chk("rnd_bus_addr", bus_addr_o, cur.addr);
                chk("rnd_bus_we", 32'(bus_we_o), 32'(cur.we));
                chk("rnd_bus_be", 32'(bus_be_o), 32'(cur.be));
                if (cur.we) chk("rnd_bus_wdata", bus_wdata_o, cur.wdata);
            end
            if (cur_v && !cur.dm && flush_i) cur.killed = 1'b1;
            if (rsp) cur_v = 1'b0;
            else if (cur_v && bus_gnt_i) begin cur.acc = 1'b1; cur.acyc = now; end
            if (exp_dm_g && if_req_i) starve = (starve < LIM) ? starve + 1 : LIM;
            else if (exp_if_g || (free && !if_req_i)) starve = 0;
            if (exp_dm_g) begin
                cur = '{dm: 1'b1, addr: dm_addr_i, we: dm_we_i, be: (dm_we_i ? dm_be_i : 4'hF),
                        wdata: dm_wdata_i, killed: 1'b0, gcyc: now, acc: 1'b0, acyc: 0};
                cur_v = 1'b1;
            end else if (exp_if_g) begin
                cur = '{dm: 1'b0, addr: if_addr_i, we: 1'b0, be: 4'hF,
                        wdata: 32'h0, killed: 1'b0, gcyc: now, acc: 1'b0, acyc: 0};
                cur_v = 1'b1;
            end
        end
        chk("rnd_proto_clean", 32'(proto_err_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
